// File: rtl/tx_ts_ctrl_pkg.sv
// Shared PTPv2 definitions for the TX timestamp controller: messageType codes,
// FSM state encoding, FIFO geometry and the two-step entry decode.
package tx_ts_ctrl_pkg;

    localparam logic [3:0] MSG_SYNC        = 4'd0;
    localparam logic [3:0] MSG_DELAY_REQ   = 4'd1;
    localparam logic [3:0] MSG_PDELAY_REQ  = 4'd2;
    localparam logic [3:0] MSG_PDELAY_RESP = 4'd3;

    localparam int unsigned TS_FIFO_DEPTH = 4;
    localparam int unsigned TS_PTR_W      = 2;
    localparam int unsigned TS_CNT_W      = 3;

    localparam int unsigned TS_W      = 80;
    localparam int unsigned FRAC_W    = 16;
    localparam int unsigned MSGTYPE_W = 4;
    localparam int unsigned SEQID_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_INFO = 2'd1,
        ST_PUSH      = 2'd2,
        ST_WAIT_EOF  = 2'd3
    } tx_ts_state_e;

    // Only event messages (codes 0..3) that are not stamped in-line need a host entry.
    function automatic logic two_step_required(
        input logic       one_step,
        input logic       one_step_from_pkt,
        input logic       is_ptp,
        input logic [3:0] msg_type,
        input logic       two_step_flag
    );
        logic one_step_flag;
        one_step_flag = one_step |
            (one_step_from_pkt & ~two_step_flag &
             ((msg_type == MSG_SYNC) || (msg_type == MSG_PDELAY_RESP)));
        return is_ptp & (msg_type <= MSG_PDELAY_RESP) & ~one_step_flag;
    endfunction

endpackage

// File: rtl/tx_ts_ctrl_fifo.sv
// tx_ts_fifo: 4-deep show-ahead timestamp FIFO with occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module tx_ts_fifo
    import tx_ts_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 100
) (
    input  logic                tx_clk,
    input  logic                tx_rst,
    input  logic                push_i,
    input  logic                pop_i,
    input  logic [WIDTH-1:0]    data_i,
    output logic [WIDTH-1:0]    data_o,
    output logic                full_o,
    output logic                empty_o,
    output logic [TS_CNT_W-1:0] count_o
);

    logic [WIDTH-1:0]    mem_q [TS_FIFO_DEPTH];
    logic [WIDTH-1:0]    mem_d [TS_FIFO_DEPTH];
    logic [TS_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [TS_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [TS_CNT_W-1:0] count_q, count_d;
    logic                push_ok, pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == TS_CNT_W'(TS_FIFO_DEPTH));

    always_comb begin
        pop_ok   = pop_i & ~empty_o;
        push_ok  = push_i & (~full_o | pop_ok);
        mem_d    = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = data_i;
        end
        wr_ptr_d = wr_ptr_q + TS_PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + TS_PTR_W'(pop_ok);
        count_d  = count_q + TS_CNT_W'(push_ok) - TS_CNT_W'(pop_ok);
    end

    always_ff @(posedge tx_clk or posedge tx_rst) begin
        if (tx_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge tx_clk) begin
        mem_q <= mem_d;
    end

    // Head is forced to zero when empty so stale storage never reaches the outputs.
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/tx_ts_ctrl.sv
// TX PTP timestamp controller: SOF timestamp capture, two-step decode and host FIFO.
// Define TX_TS_FRAC_NS_EN to store and output fractional nanoseconds.
module tx_ts_ctrl
    import tx_ts_ctrl_pkg::*;
(
    input  logic        tx_clk,
    input  logic        tx_rst,
    input  logic        tx_clk_en_i,
    input  logic [31:0] tsu_cfg_i,
    input  logic        get_sfd_done_i,
    input  logic [79:0] sfd_timestamp_i,
    input  logic [15:0] sfd_timestamp_frac_ns_i,
    input  logic        ptp_info_vld_i,
    input  logic        is_ptp_message_i,
    input  logic [3:0]  ptp_messageType_i,
    input  logic [15:0] ptp_flagField_i,
    input  logic [15:0] ptp_sequenceId_i,
    input  logic        eof_i,
    output logic        ts_vld_o,
    input  logic        ts_rdy_i,
    output logic [79:0] ts_data_o,
    output logic [15:0] ts_frac_ns_o,
    output logic [3:0]  ts_msgtype_o,
    output logic [15:0] ts_seqid_o,
    output logic [2:0]  ts_cnt_o,
    output logic [7:0]  ovf_cnt_o,
    output logic        busy_o
);

`ifdef TX_TS_FRAC_NS_EN
    localparam int unsigned ENTRY_W = TS_W + FRAC_W + MSGTYPE_W + SEQID_W;
    logic [FRAC_W-1:0] frac_q, frac_d;
`else
    localparam int unsigned ENTRY_W = TS_W + MSGTYPE_W + SEQID_W;
`endif

    tx_ts_state_e     state_q, state_d;
    logic             sfd_q, sfd_d;
    logic [TS_W-1:0]  ts_q, ts_d;
    logic [3:0]       msgtype_q, msgtype_d;
    logic [15:0]      seqid_q, seqid_d;
    logic [7:0]       ovf_q, ovf_d;
    logic             sof, need_entry, info_take;
    logic             push_req, pop, drop;
    logic             fifo_full, fifo_empty;
    logic [ENTRY_W-1:0] wr_entry, rd_entry;

    assign sof = tx_clk_en_i & get_sfd_done_i & ~sfd_q;
    assign need_entry = two_step_required(tsu_cfg_i[0], tsu_cfg_i[24], is_ptp_message_i,
                                          ptp_messageType_i, ptp_flagField_i[9]);

    always_ff @(posedge tx_clk or posedge tx_rst) begin
        if (tx_rst) begin
            state_q   <= ST_IDLE;
            sfd_q     <= 1'b0;
            ts_q      <= '0;
            msgtype_q <= '0;
            seqid_q   <= '0;
            ovf_q     <= '0;
`ifdef TX_TS_FRAC_NS_EN
            frac_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            sfd_q     <= sfd_d;
            ts_q      <= ts_d;
            msgtype_q <= msgtype_d;
            seqid_q   <= seqid_d;
            ovf_q     <= ovf_d;
`ifdef TX_TS_FRAC_NS_EN
            frac_q    <= frac_d;
`endif
        end
    end

    // A new SOF overrides every state, abandoning any frame still in progress.
    always_comb begin
        state_d = state_q;
        if (sof) begin
            state_d = ST_WAIT_INFO;
        end else if (tx_clk_en_i) begin
            unique case (state_q)
                ST_IDLE:      state_d = ST_IDLE;
                ST_WAIT_INFO: begin
                    if (ptp_info_vld_i) begin
                        state_d = need_entry ? ST_PUSH : ST_WAIT_EOF;
                    end else if (eof_i) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_PUSH:      state_d = ST_WAIT_EOF;
                ST_WAIT_EOF:  if (eof_i) state_d = ST_IDLE;
                default:      state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        sfd_d     = tx_clk_en_i ? get_sfd_done_i : sfd_q;
        ts_d      = sof ? sfd_timestamp_i : ts_q;
        info_take = tx_clk_en_i & ~sof & (state_q == ST_WAIT_INFO) & ptp_info_vld_i;
        msgtype_d = info_take ? ptp_messageType_i : msgtype_q;
        seqid_d   = info_take ? ptp_sequenceId_i : seqid_q;
`ifdef TX_TS_FRAC_NS_EN
        frac_d    = sof ? sfd_timestamp_frac_ns_i : frac_q;
`endif
        push_req  = tx_clk_en_i & ~sof & (state_q == ST_PUSH);
        pop       = tx_clk_en_i & ts_rdy_i & ~fifo_empty;
        drop      = push_req & fifo_full & ~pop;
        ovf_d     = ovf_q;
        if (drop && (ovf_q != 8'hFF)) begin
            ovf_d = ovf_q + 8'd1;
        end
    end

`ifdef TX_TS_FRAC_NS_EN
    assign wr_entry = {ts_q, frac_q, msgtype_q, seqid_q};
    assign {ts_data_o, ts_frac_ns_o, ts_msgtype_o, ts_seqid_o} = rd_entry;
    logic unused_inputs;
    assign unused_inputs = ^{tsu_cfg_i[31:25], tsu_cfg_i[23:1],
                             ptp_flagField_i[15:10], ptp_flagField_i[8:0]};
`else
    assign wr_entry = {ts_q, msgtype_q, seqid_q};
    assign {ts_data_o, ts_msgtype_o, ts_seqid_o} = rd_entry;
    assign ts_frac_ns_o = '0;
    logic unused_inputs;
    assign unused_inputs = ^{tsu_cfg_i[31:25], tsu_cfg_i[23:1],
                             ptp_flagField_i[15:10], ptp_flagField_i[8:0],
                             sfd_timestamp_frac_ns_i};
`endif

    tx_ts_fifo #(
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .tx_clk  (tx_clk),
        .tx_rst  (tx_rst),
        .push_i  (push_req),
        .pop_i   (pop),
        .data_i  (wr_entry),
        .data_o  (rd_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (ts_cnt_o)
    );

    assign ts_vld_o  = ~fifo_empty;
    assign ovf_cnt_o = ovf_q;
    assign busy_o    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tx_ts_ctrl.sv
// Directed, table-driven bench for tx_ts_ctrl with hand-written corner sequences.
module tb_tx_ts_ctrl;

    logic        tx_clk = 1'b0;
    logic        tx_rst = 1'b1;
    logic        en = 1'b1;
    logic [31:0] tsu_cfg = '0;
    logic        get_sfd = 1'b0;
    logic [79:0] sfd_ts = '0;
    logic [15:0] sfd_frac = '0;
    logic        info_vld = 1'b0;
    logic        is_ptp_i = 1'b0;
    logic [3:0]  mt_i = '0;
    logic [15:0] flag_i = '0;
    logic [15:0] seq_i = '0;
    logic        eof = 1'b0;
    logic        rdy = 1'b0;
    logic        ts_vld;
    logic [79:0] ts_data;
    logic [15:0] ts_frac;
    logic [3:0]  ts_mt;
    logic [15:0] ts_seq;
    logic [2:0]  ts_cnt;
    logic [7:0]  ovf;
    logic        busy;

    int unsigned en_div = 1;
    int n_cmp = 0;
    int n_bad = 0;

    tx_ts_ctrl dut (
        .tx_clk                  (tx_clk),
        .tx_rst                  (tx_rst),
        .tx_clk_en_i             (en),
        .tsu_cfg_i               (tsu_cfg),
        .get_sfd_done_i          (get_sfd),
        .sfd_timestamp_i         (sfd_ts),
        .sfd_timestamp_frac_ns_i (sfd_frac),
        .ptp_info_vld_i          (info_vld),
        .is_ptp_message_i        (is_ptp_i),
        .ptp_messageType_i       (mt_i),
        .ptp_flagField_i         (flag_i),
        .ptp_sequenceId_i        (seq_i),
        .eof_i                   (eof),
        .ts_vld_o                (ts_vld),
        .ts_rdy_i                (rdy),
        .ts_data_o               (ts_data),
        .ts_frac_ns_o            (ts_frac),
        .ts_msgtype_o            (ts_mt),
        .ts_seqid_o              (ts_seq),
        .ts_cnt_o                (ts_cnt),
        .ovf_cnt_o               (ovf),
        .busy_o                  (busy)
    );

    always #5 tx_clk = ~tx_clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [31:0] cfg;
        logic        is_ptp;
        logic [3:0]  mt;
        logic [15:0] flag;
        logic [15:0] seq;
        logic        exp_push;
    } vec_t;

    localparam int NV = 13;
    vec_t vec [NV];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [79:0] ts_of(input int unsigned i);
        return {16'hA5A5, i, 32'hC0DE_0000 ^ i};
    endfunction

    function automatic logic [15:0] frac_of(input int unsigned i);
        return 16'h5A00 | i[15:0];
    endfunction

    function automatic logic [15:0] exp_frac(input logic [15:0] f);
`ifdef TX_TS_FRAC_NS_EN
        return f;
`else
        return (f & 16'h0000);
`endif
    endfunction

    // Advance exactly one enabled clock edge, preceded by en_div-1 disabled edges.
    task automatic step();
        for (int unsigned k = 1; k < en_div; k++) begin
            en = 1'b0;
            @(posedge tx_clk);
            #1;
        end
        en = 1'b1;
        @(posedge tx_clk);
        #1;
    endtask

    task automatic run_frame(input logic [31:0] cfg, input logic is_ptp, input logic [3:0] mt,
                             input logic [15:0] flag, input logic [15:0] seq,
                             input logic [79:0] ts, input logic [15:0] frac,
                             input bit chk_lat, input bit pop_in_push);
        tsu_cfg  = cfg;
        get_sfd  = 1'b1;
        sfd_ts   = ts;
        sfd_frac = frac;
        step();
        sfd_ts   = ~ts;
        sfd_frac = ~frac;
        check("busy_in_frame", 128'(busy), 128'(1));
        step();
        info_vld = 1'b1;
        is_ptp_i = is_ptp;
        mt_i     = mt;
        flag_i   = flag;
        seq_i    = seq;
        step();
        info_vld = 1'b0;
        mt_i     = 4'hF;
        seq_i    = ~seq;
        if (chk_lat) check("latency_info_plus1", 128'(ts_vld), 128'(0));
        if (pop_in_push) rdy = 1'b1;
        step();
        rdy = 1'b0;
        if (chk_lat) check("latency_info_plus2", 128'(ts_vld), 128'(1));
        eof     = 1'b1;
        get_sfd = 1'b0;
        step();
        eof = 1'b0;
        check("busy_after_eof", 128'(busy), 128'(0));
    endtask

    task automatic pop_one();
        rdy = 1'b1;
        step();
        rdy = 1'b0;
    endtask

    task automatic run_table();
        for (int i = 0; i < NV; i++) begin
            run_frame(vec[i].cfg, vec[i].is_ptp, vec[i].mt, vec[i].flag, vec[i].seq,
                      ts_of(i), frac_of(i), vec[i].exp_push, 1'b0);
            check($sformatf("v%0d_cnt", i), 128'(ts_cnt), 128'(vec[i].exp_push ? 1 : 0));
            check($sformatf("v%0d_ovf", i), 128'(ovf), 128'(0));
            if (vec[i].exp_push) begin
                check($sformatf("v%0d_data", i), 128'(ts_data), 128'(ts_of(i)));
                check($sformatf("v%0d_seq", i), 128'(ts_seq), 128'(vec[i].seq));
                check($sformatf("v%0d_mt", i), 128'(ts_mt), 128'(vec[i].mt));
                check($sformatf("v%0d_frac", i), 128'(ts_frac), 128'(exp_frac(frac_of(i))));
                pop_one();
                check($sformatf("v%0d_vld_after_pop", i), 128'(ts_vld), 128'(0));
            end
        end
    endtask

    initial begin
        vec[0]  = '{32'h0000_0000, 1'b1, 4'd0, 16'h0200, 16'h0012, 1'b1};
        vec[1]  = '{32'h0000_0001, 1'b1, 4'd0, 16'h0000, 16'h0021, 1'b0};
        vec[2]  = '{32'h0100_0000, 1'b1, 4'd0, 16'h0000, 16'h0022, 1'b0};
        vec[3]  = '{32'h0100_0000, 1'b1, 4'd0, 16'h0200, 16'h0023, 1'b1};
        vec[4]  = '{32'h0000_0000, 1'b1, 4'd1, 16'h0000, 16'h0024, 1'b1};
        vec[5]  = '{32'h0100_0000, 1'b1, 4'd1, 16'h0000, 16'h0025, 1'b1};
        vec[6]  = '{32'h0100_0000, 1'b1, 4'd3, 16'h0000, 16'h0026, 1'b0};
        vec[7]  = '{32'h0000_0000, 1'b1, 4'd8, 16'h0000, 16'h0027, 1'b0};
        vec[8]  = '{32'h0000_0000, 1'b0, 4'd0, 16'h0200, 16'h0028, 1'b0};
        vec[9]  = '{32'hFEFF_FFFE, 1'b1, 4'd2, 16'h0000, 16'h0029, 1'b1};
        vec[10] = '{32'h0000_0001, 1'b1, 4'd2, 16'h0200, 16'h002A, 1'b0};
        vec[11] = '{32'h0100_0000, 1'b1, 4'd0, 16'hFDFF, 16'h002B, 1'b0};
        vec[12] = '{32'h0000_0000, 1'b1, 4'd3, 16'h0000, 16'hFFFF, 1'b1};

        // Reset state
        repeat (3) @(posedge tx_clk);
        #1;
        check("rst_vld", 128'(ts_vld), 128'(0));
        check("rst_cnt", 128'(ts_cnt), 128'(0));
        check("rst_ovf", 128'(ovf), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_data", 128'(ts_data), 128'(0));
        tx_rst = 1'b0;
        step();

        run_table();

        // Missing eof: the second SOF aborts the first frame and relatches.
        tsu_cfg = '0;
        get_sfd = 1'b1;
        sfd_ts  = 80'h1111_2222_3333_4444_5555;
        step();
        step();
        get_sfd = 1'b0;
        step();
        check("abort_busy_hold", 128'(busy), 128'(1));
        get_sfd = 1'b1;
        sfd_ts  = 80'h6666_7777_8888_9999_AAAA;
        step();
        sfd_ts   = '0;
        info_vld = 1'b1;
        is_ptp_i = 1'b1;
        mt_i     = 4'd0;
        flag_i   = 16'h0200;
        seq_i    = 16'h0AB0;
        step();
        info_vld = 1'b0;
        step();
        step();
        check("abort_cnt", 128'(ts_cnt), 128'(1));
        check("abort_data", 128'(ts_data), 128'(80'h6666_7777_8888_9999_AAAA));
        check("abort_seq", 128'(ts_seq), 128'(16'h0AB0));
        eof     = 1'b1;
        get_sfd = 1'b0;
        step();
        eof = 1'b0;
        check("abort_busy_eof", 128'(busy), 128'(0));
        pop_one();
        check("abort_cnt_pop", 128'(ts_cnt), 128'(0));

        // Overflow: six two-step frames, no pops.
        for (int k = 1; k <= 6; k++) begin
            run_frame(32'h0, 1'b1, 4'd0, 16'h0200, 16'(k), ts_of(100 + k), frac_of(k),
                      (k == 1), 1'b0);
            check($sformatf("ovf_f%0d_cnt", k), 128'(ts_cnt), 128'((k > 4) ? 4 : k));
            check($sformatf("ovf_f%0d_ovf", k), 128'(ovf), 128'((k > 4) ? k - 4 : 0));
        end
        check("ovf_head_seq", 128'(ts_seq), 128'(16'd1));
        check("ovf_head_data", 128'(ts_data), 128'(ts_of(101)));

        // Saturation: 254 further drops would reach 256 without the clamp.
        for (int k = 0; k < 254; k++) begin
            run_frame(32'h0, 1'b1, 4'd1, 16'h0000, 16'h0100, ts_of(500), 16'h0, 1'b0, 1'b0);
        end
        check("ovf_saturated", 128'(ovf), 128'(255));
        check("ovf_sat_cnt", 128'(ts_cnt), 128'(4));

        // Full FIFO with pop in the PUSH cycle: entry accepted, no drop counted.
        run_frame(32'h0, 1'b1, 4'd0, 16'h0200, 16'd7, ts_of(107), frac_of(7), 1'b0, 1'b1);
        check("fullpop_cnt", 128'(ts_cnt), 128'(4));
        check("fullpop_ovf", 128'(ovf), 128'(255));
        check("fullpop_head", 128'(ts_seq), 128'(16'd2));
        for (int k = 2; k <= 4; k++) begin
            check($sformatf("drain_seq%0d", k), 128'(ts_seq), 128'(k));
            check($sformatf("drain_data%0d", k), 128'(ts_data), 128'(ts_of(100 + k)));
            pop_one();
        end
        check("drain_seq7", 128'(ts_seq), 128'(16'd7));
        check("drain_data7", 128'(ts_data), 128'(ts_of(107)));
        check("drain_cnt", 128'(ts_cnt), 128'(1));

        // Asynchronous reset while in WAIT_INFO with an entry and a saturated counter.
        get_sfd = 1'b1;
        sfd_ts  = 80'hDEAD_BEEF_0000_1234_5678;
        step();
        check("arst_pre_busy", 128'(busy), 128'(1));
        #2;
        tx_rst = 1'b1;
        #1;
        check("arst_busy", 128'(busy), 128'(0));
        check("arst_vld", 128'(ts_vld), 128'(0));
        check("arst_cnt", 128'(ts_cnt), 128'(0));
        check("arst_ovf", 128'(ovf), 128'(0));
        check("arst_data", 128'(ts_data), 128'(0));
        check("arst_seq", 128'(ts_seq), 128'(0));
        check("arst_mt", 128'(ts_mt), 128'(0));
        check("arst_frac", 128'(ts_frac), 128'(0));
        get_sfd = 1'b0;
        repeat (2) @(posedge tx_clk);
        #1;
        tx_rst = 1'b0;
        info_vld = 1'b1;
        is_ptp_i = 1'b1;
        mt_i     = 4'd0;
        flag_i   = 16'h0200;
        seq_i    = 16'h0BAD;
        step();
        info_vld = 1'b0;
        step();
        step();
        check("post_rst_no_capture_cnt", 128'(ts_cnt), 128'(0));
        check("post_rst_busy", 128'(busy), 128'(0));

        // Clock-enable qualified 1-in-10: identical results in enabled cycles.
        en_div = 10;
        run_table();
        en_div = 1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
